// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial
//   Digit-serial BCD adder/subtractor. One decimal digit is processed per
//   clock, least significant digit first. Subtraction adds the nines'
//   complement of B with an inverted borrow as the initial carry, so a
//   borrow shows up as cout=0 and a ten's-complement result.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands/mode valid
//   in_ready   high while IDLE (combinational)
//   a, b       packed BCD operands, digit 0 in bits [3:0]
//   cin        add: carry-in, sub: borrow-in
//   sub        0 = A+B+cin, 1 = A-B-cin
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        packed BCD result
//   cout       add: carry-out, sub: 1 = no borrow
//   err        some nibble of a or b was above 9
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit per cycle, index 0..NDIG-1
// DONE  | result presented, waiting for out_ready

module bcd_addsub_serial #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  acc;
  logic          sub_r;
  logic          carry;
  logic          err_acc;

  // digit datapath for the current LSD of the shifted operands
  logic [3:0]    a_d;
  logic [3:0]    b_d;
  logic [3:0]    bd;
  logic [4:0]    s;
  logic [4:0]    s_adj;
  logic [3:0]    digit;
  logic          carry_next;
  logic          bad_digit;
  logic [W+3:0]  acc_cat;
  logic [W-1:0]  acc_next;

  always_comb begin
    a_d        = a_sh[3:0];
    b_d        = b_sh[3:0];
    // nines' complement of b wraps mod 16 for invalid digits, by design
    bd         = sub_r ? (4'd9 - b_d) : b_d;
    s          = {1'b0, a_d} + {1'b0, bd} + {4'd0, carry};
    s_adj      = s + 5'd6;
    carry_next = (s > 5'd9);
    digit      = carry_next ? s_adj[3:0] : s[3:0];
    bad_digit  = (a_d > 4'd9) || (b_d > 4'd9);
    // new digit enters at the top; after NDIG shifts digit 0 sits at [3:0]
    acc_cat    = {digit, acc};
    acc_next   = acc_cat[W+3:4];
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      sub_r     <= 1'b0;
      carry     <= 1'b0;
      err_acc   <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            sub_r   <= sub;
            carry   <= sub ? ~cin : cin;
            err_acc <= 1'b0;
            acc     <= '0;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          acc     <= acc_next;
          carry   <= carry_next;
          err_acc <= err_acc | bad_digit;
          if (idx == LAST_IDX) begin
            sum       <= acc_next;
            cout      <= carry_next;
            err       <= err_acc | bad_digit;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
module tb_bcd_addsub_serial;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Present one operation and wait for its result; latency counts edges
  // after the accepting edge until out_valid is seen high.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vcin, input logic vsub);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout waiting for out_valid: got=0 expected=1");
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drops", out_valid, 0);
    check("in_ready_returns", in_ready, 1);
  endtask

  int lat;
  logic [W-1:0] held_sum;

  initial begin
    vecs[0] = '{"add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_0_0_cin",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{"sub_5000_1234", 16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{"sub_1234_5000", 16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{"sub_0_0_bin",   16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
    vecs[6] = '{"add_err_a",     16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1};
    vecs[7] = '{"add_9999_9999", 16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    // digit 3: 0+15=15 -> (21)[3:0]=5, carry out
    vecs[8] = '{"add_err_b",     16'h0000, 16'hF000, 1'b0, 1'b0, 16'h5000, 1'b1, 1'b1};
    // digit 0: bd=(9-15) mod 16=10, s=0+10+1=11 -> 1 carry; digits 1..3: 0+9+1 -> 0 carry
    vecs[9] = '{"sub_err_b",     16'h0000, 16'h000F, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_err", err, 0);
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_result(lat);
      check({vecs[i].name, "_latency"}, lat, NDIG);
      check({vecs[i].name, "_sum"}, sum, vecs[i].exp_sum);
      check({vecs[i].name, "_cout"}, cout, vecs[i].exp_cout);
      check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
      release_result();
    end

    // backpressure plus ignored in_valid during RUN
    start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_run", in_ready, 0);
    a = 16'h9999; b = 16'h9999; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    wait_result(lat);
    check("bp_latency", lat, NDIG - 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_held", out_valid, 1);
      check("bp_sum_held", sum, 16'h6912);
      check("bp_cout_held", cout, 0);
      check("bp_err_held", err, 0);
      check("bp_in_ready_low", in_ready, 0);
    end
    release_result();
    @(posedge clk);
    #1;
    check("bp_no_second_result", out_valid, 0);

    // reset in RUN after digit 1 aborts the operation
    start_op(16'h5000, 16'h1234, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_result", out_valid, 0);
    start_op(16'h4321, 16'h0679, 1'b0, 1'b0);
    wait_result(lat);
    check("post_rst_latency", lat, NDIG);
    check("post_rst_sum", sum, 16'h5000);
    check("post_rst_cout", cout, 0);
    release_result();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
